// File: rtl/imem_loader.sv
// Instruction RAM filled from a little-endian byte stream; holds the core in reset until s_last.
// Writes land on the handshake edge, reads are combinational; s_ready drops in RUN and during reload.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  input  logic          reload,
  input  logic [31:0]   pc_a,
  output logic [31:0]   instr_rd,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_byte_idx;
  logic [AW:0]   r_word_ptr;
  logic [31:0]   r_asm;
  logic          r_load_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_full;
  logic          w_word_done;
  logic          w_wr_en;
  logic [31:0]   w_word;
  logic          w_unused_pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (reload) begin
      w_state_nxt = ST_LOAD;
    end else if (w_accept && s_last) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Output logic: s_ready never looks at s_valid or s_data
  always_comb begin
    s_ready   = 1'b0;
    cpu_reset = 1'b1;
    load_done = 1'b0;
    case (r_state)
      ST_LOAD: begin
        s_ready   = ~reload;
        cpu_reset = 1'b1;
        load_done = 1'b0;
      end
      ST_RUN: begin
        s_ready   = 1'b0;
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      default: begin
        s_ready   = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
      end
    endcase
  end

  assign w_accept    = s_valid & s_ready;
  assign w_full      = (r_word_ptr == C_FULL);
  assign w_word_done = w_accept & (s_last | (r_byte_idx == 2'd3));
  assign w_wr_en     = w_word_done & ~w_full;

  // Assembly register keeps unfilled upper bytes at zero, so a short final word pads itself.
  assign w_word = r_asm | (32'(s_data) << {r_byte_idx, 3'b000});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx <= '0;
      r_word_ptr <= '0;
      r_asm      <= '0;
      r_load_err <= 1'b0;
    end else if (reload) begin
      r_byte_idx <= '0;
      r_word_ptr <= '0;
      r_asm      <= '0;
      r_load_err <= 1'b0;
    end else if (w_accept) begin
      r_byte_idx <= s_last ? 2'd0 : r_byte_idx + 2'd1;
      r_asm      <= w_word_done ? 32'd0 : w_word;
      if (w_full) begin
        r_load_err <= 1'b1;
      end
      if (w_wr_en) begin
        r_word_ptr <= r_word_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_word_ptr[AW-1:0]] <= w_word;
    end
  end

  // Word-aligned fetch; byte offset and upper PC bits wrap the address space.
  assign instr_rd     = r_mem[pc_a[AW+1:2]];
  assign w_unused_pc  = ^{pc_a[31:AW+2], pc_a[1:0]};

  assign load_err     = r_load_err;
  assign words_loaded = r_word_ptr;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: image-level reference model, scoreboard queues, decoupled monitor.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int     nbytes;
    int     words;
    logic   err;
    longint edge_n;
  } done_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        reload;
  logic [31:0] pc_a;
  logic [31:0] instr_rd;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [6:0]  words_loaded;

  imem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .reload       (reload),
    .pc_a         (pc_a),
    .instr_rd     (instr_rd),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int        n_vec = 0;
  int        n_bad = 0;
  longint    cyc = 0;
  int        hs_cnt = 0;
  int        done_cnt = 0;
  logic      rd_vld = 1'b0;
  logic      prev_done = 1'b0;
  done_exp_t q_done[$];
  rd_exp_t   q_rd[$];

  logic [31:0] m_mem[64];
  bit          m_known[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) hs_cnt <= 0;
    else if (reload) hs_cnt <= 0;
    else if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
  end

  // Monitor: completed loads and read probes are checked against queued expectations.
  always @(negedge clk) begin
    done_exp_t e;
    rd_exp_t   r;
    if (!reset && load_done === 1'b1 && prev_done !== 1'b1) begin
      done_cnt++;
      if (q_done.size() == 0) begin
        chk("unexpected_load_done", 64'd1, 64'd0);
      end else begin
        e = q_done.pop_front();
        chk("words_loaded", 64'(words_loaded), 64'(e.words));
        chk("load_err", 64'(load_err), 64'(e.err));
        chk("cpu_reset_run", 64'(cpu_reset), 64'd0);
        chk("release_edge", 64'(cyc), 64'(e.edge_n));
        chk("handshake_count", 64'(hs_cnt), 64'(e.nbytes));
      end
    end
    prev_done <= load_done;
    if (rd_vld) begin
      if (q_rd.size() == 0) begin
        chk("unexpected_read", 64'd1, 64'd0);
      end else begin
        r = q_rd.pop_front();
        chk($sformatf("instr_rd[pc=%08h]", r.pc), 64'(instr_rd), 64'(r.data));
      end
    end
  end

  // Reference model: packs the first nwords words of an image, little-endian, zero-padded.
  task automatic model_write(input bq_t img, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word;
      word = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < img.size()) word = word | (32'(img[4*w+b]) << (8*b));
      m_mem[w] = word;
      m_known[w] = 1'b1;
    end
  endtask

  task automatic send_bytes(input bq_t img, input int nsend, input int gap_pct);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = img[i];
      s_last  = (i == img.size() - 1);
      #1;
      chk("s_ready_load", 64'(s_ready), 64'd1);
      chk("cpu_reset_load", 64'(cpu_reset), 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic load_image(input bq_t img, input int gap_pct);
    done_exp_t e;
    int start, nw;
    start = done_cnt;
    nw = (img.size() + 3) / 4;
    send_bytes(img, img.size(), gap_pct);
    e.nbytes = img.size();
    e.words  = (nw > 64) ? 64 : nw;
    e.err    = (nw > 64);
    e.edge_n = cyc;
    q_done.push_back(e);
    model_write(img, e.words);
    for (int t = 0; t < 10 && done_cnt == start; t++) @(posedge clk);
    chk("load_done_seen", 64'(done_cnt - start), 64'd1);
  endtask

  task automatic probe(input logic [31:0] pc);
    rd_exp_t r;
    @(posedge clk);
    #1;
    pc_a   = pc;
    r.pc   = pc;
    r.data = m_mem[pc[7:2]];
    q_rd.push_back(r);
    rd_vld = 1'b1;
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic probe_all();
    for (int w = 0; w < 64; w++)
      if (m_known[w]) probe(($urandom & 32'hFFFF_FF03) | (32'(w) << 2));
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    s_last  = 1'b1;
    #1;
    chk("s_ready_reload", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    reload  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("reload_load_done", 64'(load_done), 64'd0);
    chk("reload_words", 64'(words_loaded), 64'd0);
    chk("reload_err", 64'(load_err), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t img;
    for (int w = 0; w < 64; w++) m_known[w] = 1'b0;
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; reload = 1'b0; pc_a = 32'd0;
    #3;
    chk_reset_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    @(negedge clk);
    reset = 1'b0;

    // Two full words
    img = '{8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h10, 8'hA0, 8'hE3};
    load_image(img, 0);
    probe(32'h0000_0000);
    probe(32'h0000_0004);

    // Partial final word padded with zeros
    do_reload();
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_image(img, 0);
    probe(32'h0000_0004);
    probe(32'h0000_0000);

    // Same image as the first, with idle gaps
    do_reload();
    img = '{8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h10, 8'hA0, 8'hE3};
    load_image(img, 50);
    probe_all();

    // Overflow: 65 words into a 64-word RAM
    do_reload();
    img = {};
    for (int i = 0; i < 260; i++) img.push_back(8'($urandom));
    load_image(img, 10);
    probe_all();

    // Stream activity in RUN is ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
      #1;
      chk("s_ready_run", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("run_words_hold", 64'(words_loaded), 64'd64);
    chk("run_err_hold", 64'(load_err), 64'd1);
    chk("run_done_hold", 64'(load_done), 64'd1);
    probe(32'h0000_0000);
    probe(32'h0000_00FC);

    // Reload clears the error; old RAM words beyond the new image survive
    do_reload();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image(img, 0);
    probe(32'h0000_0000);
    probe(32'h0000_0004);
    probe(32'h0000_0100);

    // Random images, some overflowing
    for (int it = 0; it < 6; it++) begin
      do_reload();
      img = {};
      for (int i = 0; i < int'($urandom_range(300, 1)); i++) img.push_back(8'($urandom));
      load_image(img, 30);
      for (int k = 0; k < 8; k++) begin
        int w;
        w = $urandom_range(63);
        if (m_known[w]) probe(($urandom & 32'hFFFF_FF03) | (32'(w) << 2));
      end
    end

    // Reset in the middle of a load
    do_reload();
    img = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    send_bytes(img, 5, 0);
    model_write(img, 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    img = '{8'h78, 8'h56, 8'h34, 8'h12};
    load_image(img, 0);
    probe(32'h0000_0000);
    probe(32'h0000_0104);

    repeat (3) @(posedge clk);
    chk("done_queue_empty", 64'(q_done.size()), 64'd0);
    chk("read_queue_empty", 64'(q_rd.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
